// File: rtl/SB_codex_pkg.sv
// rtl/SB_codex_pkg.sv - Sideband message codes shared by the LTSM stages.
package SB_codex_pkg;

  typedef enum logic [7:0] {
    SB_NOP                   = 8'h00,
    SB_TRAINERROR_ENTRY_REQ  = 8'h01,
    SB_TRAINERROR_ENTRY_RESP = 8'h02,
    SB_MBTRAIN_DONE_REQ      = 8'h10,
    SB_MBTRAIN_DONE_RESP     = 8'h11,
    SB_LINKINIT_REQ          = 8'h20,
    SB_LINKINIT_RESP         = 8'h21
  } SB_msg_t;

endpackage

// File: rtl/sb_timeout_counter.sv
// rtl/sb_timeout_counter.sv - Saturating cycle counter; expired holds once MAX-1 is reached.
module sb_timeout_counter #(
  parameter int MAX = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = (MAX > 1) ? $clog2(MAX) : 1;
  localparam logic [W-1:0] LAST = W'(MAX - 1);

  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_count <= '0;
    end else if (enable && (r_count != LAST)) begin
      r_count <= r_count + W'(1);
    end
  end

  assign expired = (r_count == LAST);

endmodule

// File: rtl/linkinit.sv
// rtl/linkinit.sv - LINKINIT stage: sideband REQ/RESP handshake with resend and timeout.
module linkinit
  import SB_codex_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 800000,
  parameter int RESEND_CYCLES  = 1000
) (
  input  logic        clk_100MHz,
  input  logic        reset,
  input  logic        enable_i,
  output logic [1:0]  MB_clkPins_TX_LINKINIT_o,
  output logic [15:0] MB_dataPins_TX_LINKINIT_o,
  output logic        LINKINIT_done_o,
  output logic        LINKINIT_error_o,
  output SB_msg_t     TX_msg_o,
  output logic        TX_msg_valid_o,
  input  SB_msg_t     RX_msg_i,
  input  logic        RX_msg_valid_i,
  output logic        RX_msg_req_o
);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_HANDSHAKE = 2'd1;
  localparam logic [1:0] ST_DONE      = 2'd2;
  localparam logic [1:0] ST_ERROR     = 2'd3;

  logic [1:0] r_state;
  logic       r_resp_rcvd;
  logic       r_resp_sent;
  logic       r_tx_valid;
  SB_msg_t    r_tx_msg;
  logic       r_rx_req;
  logic       r_done;
  logic       r_error;

  logic w_in_hs;
  logic w_consume;
  logic w_rx_req;
  logic w_rx_resp;
  logic w_resp_strobe;
  logic w_rcvd_next;
  logic w_sent_next;
  logic w_complete;
  logic w_timeout;
  logic w_resend_due;
  logic w_send_req;

  assign w_in_hs       = (r_state == ST_HANDSHAKE);
  assign w_consume     = r_rx_req & RX_msg_valid_i;
  assign w_rx_req      = w_consume & (RX_msg_i == SB_LINKINIT_REQ);
  assign w_rx_resp     = w_consume & (RX_msg_i == SB_LINKINIT_RESP);
  assign w_resp_strobe = r_tx_valid & (r_tx_msg == SB_LINKINIT_RESP);

  // Flags as they stand at the end of this cycle, so done follows the last event by one cycle
  assign w_rcvd_next = r_resp_rcvd | (w_in_hs & w_rx_resp);
  assign w_sent_next = r_resp_sent | (w_in_hs & w_resp_strobe);
  assign w_complete  = w_rcvd_next & w_sent_next;

  // A due resend stays due (the timer saturates) until it wins the TX slot
  assign w_send_req = w_in_hs & w_resend_due & ~w_rcvd_next & ~w_rx_req & ~w_timeout;

  sb_timeout_counter #(.MAX(TIMEOUT_CYCLES)) u_timeout (
    .clk     (clk_100MHz),
    .reset   (reset),
    .clear   (~w_in_hs),
    .enable  (w_in_hs),
    .expired (w_timeout)
  );

  sb_timeout_counter #(.MAX(RESEND_CYCLES)) u_resend (
    .clk     (clk_100MHz),
    .reset   (reset),
    .clear   (~w_in_hs | w_send_req),
    .enable  (w_in_hs),
    .expired (w_resend_due)
  );

  always_ff @(posedge clk_100MHz) begin
    if (reset || !enable_i) begin
      r_state     <= ST_IDLE;
      r_resp_rcvd <= 1'b0;
      r_resp_sent <= 1'b0;
      r_tx_valid  <= 1'b0;
      r_tx_msg    <= SB_NOP;
      r_rx_req    <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_tx_valid <= 1'b0;
      r_tx_msg   <= SB_NOP;
      case (r_state)
        ST_IDLE: begin
          r_state     <= ST_HANDSHAKE;
          r_tx_valid  <= 1'b1;
          r_tx_msg    <= SB_LINKINIT_REQ;
          r_rx_req    <= 1'b1;
          r_resp_rcvd <= 1'b0;
          r_resp_sent <= 1'b0;
        end
        ST_HANDSHAKE: begin
          r_resp_rcvd <= w_rcvd_next;
          r_resp_sent <= w_sent_next;
          if (w_timeout && !w_complete) begin
            r_state    <= ST_ERROR;
            r_error    <= 1'b1;
            r_rx_req   <= 1'b0;
            r_tx_valid <= 1'b1;
            r_tx_msg   <= SB_TRAINERROR_ENTRY_REQ;
          end else begin
            if (w_complete) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end
            if (w_rx_req) begin
              r_tx_valid <= 1'b1;
              r_tx_msg   <= SB_LINKINIT_RESP;
            end else if (w_send_req) begin
              r_tx_valid <= 1'b1;
              r_tx_msg   <= SB_LINKINIT_REQ;
            end
          end
        end
        ST_DONE: begin
          if (w_rx_req) begin
            r_tx_valid <= 1'b1;
            r_tx_msg   <= SB_LINKINIT_RESP;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign MB_clkPins_TX_LINKINIT_o  = 2'b00;
  assign MB_dataPins_TX_LINKINIT_o = 16'h0000;
  assign LINKINIT_done_o           = r_done;
  assign LINKINIT_error_o          = r_error;
  assign TX_msg_o                  = r_tx_msg;
  assign TX_msg_valid_o            = r_tx_valid;
  assign RX_msg_req_o              = r_rx_req;

endmodule

// File: tb/tb_linkinit.sv
// tb/tb_linkinit.sv - Self-checking bench for linkinit against a timestamp-based reference model.
module tb_linkinit;
  import SB_codex_pkg::*;

  localparam int TB_T = 50;
  localparam int TB_R = 10;
  localparam int MAXC = 128;

  logic        clk_100MHz = 1'b0;
  logic        reset;
  logic        enable_i;
  SB_msg_t     RX_msg_i;
  logic        RX_msg_valid_i;
  logic [1:0]  clk_pins;
  logic [15:0] data_pins;
  logic        done_o;
  logic        error_o;
  SB_msg_t     tx_msg;
  logic        tx_valid;
  logic        rx_req;

  int checks = 0;
  int errors = 0;

  logic    sch_v [MAXC];
  SB_msg_t sch_m [MAXC];
  logic    obs_v [MAXC];
  SB_msg_t obs_m [MAXC];
  logic    obs_d [MAXC];
  logic    obs_e [MAXC];
  logic    obs_q [MAXC];
  logic [17:0] obs_p [MAXC];
  logic    exp_v [MAXC];
  SB_msg_t exp_m [MAXC];
  logic    exp_d [MAXC];
  logic    exp_e [MAXC];
  logic    exp_q [MAXC];

  always #5 clk_100MHz = ~clk_100MHz;

  linkinit #(.TIMEOUT_CYCLES(TB_T), .RESEND_CYCLES(TB_R)) dut (
    .clk_100MHz                (clk_100MHz),
    .reset                     (reset),
    .enable_i                  (enable_i),
    .MB_clkPins_TX_LINKINIT_o  (clk_pins),
    .MB_dataPins_TX_LINKINIT_o (data_pins),
    .LINKINIT_done_o           (done_o),
    .LINKINIT_error_o          (error_o),
    .TX_msg_o                  (tx_msg),
    .TX_msg_valid_o            (tx_valid),
    .RX_msg_i                  (RX_msg_i),
    .RX_msg_valid_i            (RX_msg_valid_i),
    .RX_msg_req_o              (rx_req)
  );

  task automatic clear_sched();
    for (int i = 0; i < MAXC; i++) begin
      sch_v[i] = 1'b0;
      sch_m[i] = SB_NOP;
    end
  endtask

  // Cycle 0 is the first cycle enable_i is high with the block idle
  task automatic run_cycles(input int n);
    for (int c = 0; c < n; c++) begin
      enable_i       = 1'b1;
      RX_msg_valid_i = sch_v[c];
      RX_msg_i       = sch_m[c];
      @(negedge clk_100MHz);
      obs_v[c] = tx_valid;
      obs_m[c] = tx_msg;
      obs_d[c] = done_o;
      obs_e[c] = error_o;
      obs_q[c] = rx_req;
      obs_p[c] = {clk_pins, data_pins};
      @(posedge clk_100MHz);
      #1;
    end
    RX_msg_valid_i = 1'b0;
  endtask

  task automatic go_idle();
    enable_i       = 1'b0;
    RX_msg_valid_i = 1'b0;
    repeat (2) begin
      @(posedge clk_100MHz);
      #1;
    end
  endtask

  function automatic int count_msg(input int n, input SB_msg_t m);
    int k = 0;
    for (int c = 0; c < n; c++) if (obs_v[c] && obs_m[c] == m) k++;
    return k;
  endfunction

  // Reference: decisions made in cycle c appear on the outputs in cycle c+1.
  // Requests go out RESEND apart measured from the last actual send; the deadline
  // falls TIMEOUT-1 cycles after handshake entry at cycle 1, i.e. at cycle TIMEOUT.
  task automatic model(input int n);
    bit done, err, rcvd, sent, going_err, took_req, took_resp;
    int last_req;
    for (int c = 0; c < n; c++) begin
      exp_v[c] = 1'b0; exp_m[c] = SB_NOP; exp_d[c] = 1'b0; exp_e[c] = 1'b0; exp_q[c] = 1'b0;
    end
    exp_v[1] = 1'b1; exp_m[1] = SB_LINKINIT_REQ; exp_q[1] = 1'b1;
    last_req = 1;
    done = 0; err = 0; rcvd = 0; sent = 0;
    for (int c = 1; c < n - 1; c++) begin
      took_req  = !err && sch_v[c] && (sch_m[c] == SB_LINKINIT_REQ);
      took_resp = !err && sch_v[c] && (sch_m[c] == SB_LINKINIT_RESP);
      going_err = 0;
      if (!done && !err) begin
        if (took_resp) rcvd = 1;
        if (exp_v[c] && exp_m[c] == SB_LINKINIT_RESP) sent = 1;
        if (rcvd && sent) done = 1;
        else if (c >= TB_T) begin
          err = 1;
          going_err = 1;
        end
      end
      exp_d[c+1] = done;
      exp_e[c+1] = err;
      exp_q[c+1] = !err;
      if (going_err) begin
        exp_v[c+1] = 1'b1; exp_m[c+1] = SB_TRAINERROR_ENTRY_REQ;
      end else if (!err) begin
        if (took_req) begin
          exp_v[c+1] = 1'b1; exp_m[c+1] = SB_LINKINIT_RESP;
        end else if (!rcvd && (c + 1 - last_req) >= TB_R) begin
          exp_v[c+1] = 1'b1; exp_m[c+1] = SB_LINKINIT_REQ;
          last_req = c + 1;
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; enable_i = 1'b1; RX_msg_valid_i = 1'b1; RX_msg_i = SB_LINKINIT_REQ;
    repeat (3) @(posedge clk_100MHz);
    @(negedge clk_100MHz);
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid got %0b want 0", tx_valid); end
    checks++; if (tx_msg !== SB_NOP) begin errors++; $display("FAIL reset_tx_msg got %0h want %0h", tx_msg, SB_NOP); end
    checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL reset_done got %0b want 0", done_o); end
    checks++; if (error_o !== 1'b0) begin errors++; $display("FAIL reset_error got %0b want 0", error_o); end
    checks++; if (rx_req !== 1'b0) begin errors++; $display("FAIL reset_rx_req got %0b want 0", rx_req); end
    checks++; if ({clk_pins, data_pins} !== 18'd0) begin errors++; $display("FAIL reset_pins got %0h want 0", {clk_pins, data_pins}); end
    @(posedge clk_100MHz); #1;
    reset = 1'b0; RX_msg_valid_i = 1'b0;
    go_idle();
  endtask

  task automatic test_normal();
    clear_sched();
    sch_v[3] = 1'b1; sch_m[3] = SB_LINKINIT_REQ;
    sch_v[5] = 1'b1; sch_m[5] = SB_LINKINIT_RESP;
    run_cycles(12);
    model(12);
    for (int c = 0; c < 12; c++) begin
      checks++;
      if ({obs_v[c], obs_m[c], obs_d[c], obs_e[c], obs_q[c], obs_p[c]} !== {exp_v[c], exp_m[c], exp_d[c], exp_e[c], exp_q[c], 18'd0}) begin
        errors++;
        $display("FAIL normal c%0d got v%0b m%0h d%0b e%0b q%0b p%0h want v%0b m%0h d%0b e%0b q%0b", c,
                 obs_v[c], obs_m[c], obs_d[c], obs_e[c], obs_q[c], obs_p[c], exp_v[c], exp_m[c], exp_d[c], exp_e[c], exp_q[c]);
      end
    end
    checks++; if (!(obs_v[1] && obs_m[1] == SB_LINKINIT_REQ)) begin errors++; $display("FAIL normal_req_c1 got v%0b m%0h want REQ", obs_v[1], obs_m[1]); end
    checks++; if (!(obs_v[4] && obs_m[4] == SB_LINKINIT_RESP)) begin errors++; $display("FAIL normal_resp_c4 got v%0b m%0h want RESP", obs_v[4], obs_m[4]); end
    checks++; if ({obs_d[5], obs_d[6]} !== 2'b01) begin errors++; $display("FAIL normal_done_c6 got %0b%0b want 01", obs_d[5], obs_d[6]); end
    go_idle();
  endtask

  task automatic test_collision();
    clear_sched();
    sch_v[10] = 1'b1; sch_m[10] = SB_LINKINIT_REQ;
    sch_v[14] = 1'b1; sch_m[14] = SB_LINKINIT_RESP;
    run_cycles(20);
    model(20);
    for (int c = 0; c < 20; c++) begin
      checks++;
      if ({obs_v[c], obs_m[c], obs_d[c], obs_e[c], obs_q[c]} !== {exp_v[c], exp_m[c], exp_d[c], exp_e[c], exp_q[c]}) begin
        errors++;
        $display("FAIL collision c%0d got v%0b m%0h d%0b e%0b q%0b want v%0b m%0h d%0b e%0b q%0b", c,
                 obs_v[c], obs_m[c], obs_d[c], obs_e[c], obs_q[c], exp_v[c], exp_m[c], exp_d[c], exp_e[c], exp_q[c]);
      end
    end
    checks++; if (!(obs_v[11] && obs_m[11] == SB_LINKINIT_RESP)) begin errors++; $display("FAIL collision_resp_c11 got v%0b m%0h want RESP", obs_v[11], obs_m[11]); end
    checks++; if (!(obs_v[12] && obs_m[12] == SB_LINKINIT_REQ)) begin errors++; $display("FAIL collision_req_c12 got v%0b m%0h want REQ", obs_v[12], obs_m[12]); end
    checks++; if (count_msg(20, SB_LINKINIT_REQ) != 2) begin errors++; $display("FAIL collision_req_count got %0d want 2", count_msg(20, SB_LINKINIT_REQ)); end
    checks++; if ({obs_d[14], obs_d[15]} !== 2'b01) begin errors++; $display("FAIL collision_done_c15 got %0b%0b want 01", obs_d[14], obs_d[15]); end
    go_idle();
  endtask

  task automatic test_resend();
    bit want;
    clear_sched();
    run_cycles(45);
    for (int c = 0; c < 45; c++) begin
      want = (c >= 1) && ((c - 1) % TB_R == 0);
      checks++;
      if ((obs_v[c] && obs_m[c] == SB_LINKINIT_REQ) !== want) begin
        errors++;
        $display("FAIL resend c%0d got v%0b m%0h want req=%0b", c, obs_v[c], obs_m[c], want);
      end
    end
    go_idle();
  endtask

  task automatic test_timeout();
    clear_sched();
    run_cycles(60);
    model(60);
    for (int c = 0; c < 60; c++) begin
      checks++;
      if ({obs_v[c], obs_m[c], obs_d[c], obs_e[c], obs_q[c]} !== {exp_v[c], exp_m[c], exp_d[c], exp_e[c], exp_q[c]}) begin
        errors++;
        $display("FAIL timeout c%0d got v%0b m%0h d%0b e%0b q%0b want v%0b m%0h d%0b e%0b q%0b", c,
                 obs_v[c], obs_m[c], obs_d[c], obs_e[c], obs_q[c], exp_v[c], exp_m[c], exp_d[c], exp_e[c], exp_q[c]);
      end
      checks++;
      if ({obs_e[c], obs_d[c]} !== {(c >= TB_T + 1), 1'b0}) begin
        errors++;
        $display("FAIL timeout_flags c%0d got e%0b d%0b want e%0b d0", c, obs_e[c], obs_d[c], (c >= TB_T + 1));
      end
    end
    checks++; if (count_msg(60, SB_TRAINERROR_ENTRY_REQ) != 1) begin errors++; $display("FAIL timeout_te_count got %0d want 1", count_msg(60, SB_TRAINERROR_ENTRY_REQ)); end
    checks++; if (!(obs_v[TB_T+1] && obs_m[TB_T+1] == SB_TRAINERROR_ENTRY_REQ)) begin errors++; $display("FAIL timeout_te_c51 got v%0b m%0h want TE", obs_v[TB_T+1], obs_m[TB_T+1]); end
    go_idle();
  endtask

  task automatic test_done_disturb();
    clear_sched();
    sch_v[2]  = 1'b1; sch_m[2]  = SB_LINKINIT_REQ;
    sch_v[3]  = 1'b1; sch_m[3]  = SB_LINKINIT_RESP;
    sch_v[8]  = 1'b1; sch_m[8]  = SB_TRAINERROR_ENTRY_RESP;
    sch_v[10] = 1'b1; sch_m[10] = SB_LINKINIT_REQ;
    run_cycles(16);
    model(16);
    for (int c = 0; c < 16; c++) begin
      checks++;
      if ({obs_v[c], obs_m[c], obs_d[c], obs_e[c], obs_q[c]} !== {exp_v[c], exp_m[c], exp_d[c], exp_e[c], exp_q[c]}) begin
        errors++;
        $display("FAIL disturb c%0d got v%0b m%0h d%0b e%0b q%0b want v%0b m%0h d%0b e%0b q%0b", c,
                 obs_v[c], obs_m[c], obs_d[c], obs_e[c], obs_q[c], exp_v[c], exp_m[c], exp_d[c], exp_e[c], exp_q[c]);
      end
      if (c >= 4) begin
        checks++;
        if (obs_d[c] !== 1'b1) begin errors++; $display("FAIL disturb_done_held c%0d got %0b want 1", c, obs_d[c]); end
      end
    end
    checks++; if (obs_v[9] !== 1'b0) begin errors++; $display("FAIL disturb_junk_dropped got v%0b want 0", obs_v[9]); end
    checks++; if (!(obs_v[11] && obs_m[11] == SB_LINKINIT_RESP)) begin errors++; $display("FAIL disturb_dup_resp got v%0b m%0h want RESP", obs_v[11], obs_m[11]); end
    go_idle();
  endtask

  task automatic test_enable_drop();
    clear_sched();
    sch_v[4] = 1'b1; sch_m[4] = SB_LINKINIT_REQ;
    run_cycles(5);
    enable_i = 1'b0; RX_msg_valid_i = 1'b1; RX_msg_i = SB_LINKINIT_REQ;
    @(negedge clk_100MHz);
    checks++; if (!(tx_valid && tx_msg == SB_LINKINIT_RESP)) begin errors++; $display("FAIL drop_resp_c5 got v%0b m%0h want RESP", tx_valid, tx_msg); end
    @(posedge clk_100MHz); #1;
    @(negedge clk_100MHz);
    checks++;
    if ({tx_valid, tx_msg, done_o, error_o, rx_req, clk_pins, data_pins} !== {1'b0, SB_NOP, 1'b0, 1'b0, 1'b0, 18'd0}) begin
      errors++;
      $display("FAIL drop_outputs got v%0b m%0h d%0b e%0b q%0b want all 0 and NOP", tx_valid, tx_msg, done_o, error_o, rx_req);
    end
    @(posedge clk_100MHz); #1;
    @(negedge clk_100MHz);
    checks++; if ({tx_valid, rx_req} !== 2'b00) begin errors++; $display("FAIL drop_no_late_send got v%0b q%0b want 00", tx_valid, rx_req); end
    go_idle();
  endtask

  task automatic test_reset_mid();
    clear_sched();
    sch_v[2] = 1'b1; sch_m[2] = SB_LINKINIT_REQ;
    sch_v[3] = 1'b1; sch_m[3] = SB_LINKINIT_RESP;
    run_cycles(6);
    reset = 1'b1; enable_i = 1'b1;
    @(negedge clk_100MHz);
    checks++; if (done_o !== 1'b1) begin errors++; $display("FAIL rstmid_in_done got %0b want 1", done_o); end
    @(posedge clk_100MHz); #1;
    reset = 1'b0;
    @(negedge clk_100MHz);
    checks++;
    if ({tx_valid, tx_msg, done_o, error_o, rx_req} !== {1'b0, SB_NOP, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL rstmid_outputs got v%0b m%0h d%0b e%0b q%0b want 0 NOP 0 0 0", tx_valid, tx_msg, done_o, error_o, rx_req);
    end
    @(posedge clk_100MHz); #1;
    @(negedge clk_100MHz);
    checks++;
    if ({tx_valid, tx_msg, rx_req} !== {1'b1, SB_LINKINIT_REQ, 1'b1}) begin
      errors++;
      $display("FAIL rstmid_restart got v%0b m%0h q%0b want 1 REQ 1", tx_valid, tx_msg, rx_req);
    end
    @(posedge clk_100MHz); #1;
    go_idle();
  endtask

  task automatic test_random();
    int n;
    for (int it = 0; it < 8; it++) begin
      n = 70;
      for (int c = 0; c < MAXC; c++) begin
        sch_v[c] = ($urandom_range(0, 9) < 2);
        case ($urandom_range(0, 3))
          0: sch_m[c] = SB_LINKINIT_REQ;
          1: sch_m[c] = SB_LINKINIT_RESP;
          2: sch_m[c] = SB_TRAINERROR_ENTRY_RESP;
          default: sch_m[c] = SB_MBTRAIN_DONE_REQ;
        endcase
      end
      run_cycles(n);
      model(n);
      for (int c = 0; c < n; c++) begin
        checks++;
        if ({obs_v[c], obs_m[c], obs_d[c], obs_e[c], obs_q[c], obs_p[c]} !== {exp_v[c], exp_m[c], exp_d[c], exp_e[c], exp_q[c], 18'd0}) begin
          errors++;
          $display("FAIL random it%0d c%0d got v%0b m%0h d%0b e%0b q%0b want v%0b m%0h d%0b e%0b q%0b", it, c,
                   obs_v[c], obs_m[c], obs_d[c], obs_e[c], obs_q[c], exp_v[c], exp_m[c], exp_d[c], exp_e[c], exp_q[c]);
        end
      end
      go_idle();
    end
  endtask

  initial begin
    reset = 1'b1;
    enable_i = 1'b0;
    RX_msg_valid_i = 1'b0;
    RX_msg_i = SB_NOP;
    test_reset();
    test_normal();
    test_collision();
    test_resend();
    test_timeout();
    test_done_disturb();
    test_enable_drop();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
